// File: rtl/ex_pkg.sv
// Purpose: shared types and constants for the EX-stage FP sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ex_pkg;

  // Sequencer states: IDLE accepts EX work, ISSUE fires the FP start pulse,
  // BUSY waits for the FP unit (or its timeout).
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } exState_t;

  // FP unit opcodes carried on fp_op.
  localparam logic [1:0] FP_ADD = 2'd0;
  localparam logic [1:0] FP_SUB = 2'd1;
  localparam logic [1:0] FP_MUL = 2'd2;
  localparam logic [1:0] FP_DIV = 2'd3;

  // Default FP timeout, in cycles after the issue pulse.
  localparam int DEFAULT_MAX_LAT = 8;

endpackage

// File: rtl/ex_lat_counter.sv
// Purpose: clearable up-counter flagging when it holds MAX_LAT-1.
// Latency: clear/increment visible one cycle later; terminal is combinational from the count.
// Backpressure: none; the counter holds at its terminal value instead of wrapping.
//
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   clear       - force the count to zero next edge (wins over en)
//   en          - increment next edge
//   terminal    - count == MAX_LAT-1
module ex_lat_counter
  import ex_pkg::*;
#(
  parameter int MAX_LAT = DEFAULT_MAX_LAT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic terminal
);

  localparam int CW = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  logic [CW-1:0] count;

  assign terminal = (count == CW'(MAX_LAT - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en && !terminal) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fp_ex_seq.sv
// Purpose: EX-stage sequencer plus EX/MEM result register; integer results pass straight
//          through, FP ops are handed to an external FP unit and waited on.
// Latency: integer 1 cycle; FP 2 + (cycles from fp_start to fp_valid), bounded by MAX_LAT timeout.
// Backpressure: stall_ex freezes F/D/E while an FP op is accepted/in flight; MEM sees bubbles.
//
// Optional feature macro: EX_STALL_CNT_EN (saturating count of stall_ex cycles on stall_cycles).
//
// Ports:
//   clk, reset                        - clock, synchronous active-high reset
//   in_valid/in_is_fp/in_fp_op/in_rd  - EX instruction and its class/opcode/destination
//   in_int_result, in_fp_a, in_fp_b   - integer result and forwarded FP operands
//   flush_e                           - kill the EX instruction (aborts an in-flight FP op)
//   fp_start/fp_op/fp_a/fp_b/fp_kill  - FP unit issue/abort interface
//   fp_valid/fp_result                - FP unit completion
//   stall_ex                          - freeze front pipeline
//   out_valid/out_we/out_rd/out_result- EX/MEM register contents
//   fp_timeout                        - sticky "FP unit never answered" flag
//   stall_cycles                      - stall counter (zero when feature is off)
module fp_ex_seq
  import ex_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int RD_W    = 5,
  parameter int MAX_LAT = DEFAULT_MAX_LAT,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_is_fp,
  input  logic [1:0]       in_fp_op,
  input  logic [RD_W-1:0]  in_rd,
  input  logic [WIDTH-1:0] in_int_result,
  input  logic [WIDTH-1:0] in_fp_a,
  input  logic [WIDTH-1:0] in_fp_b,
  input  logic             flush_e,
  output logic             fp_start,
  output logic [1:0]       fp_op,
  output logic [WIDTH-1:0] fp_a,
  output logic [WIDTH-1:0] fp_b,
  output logic             fp_kill,
  input  logic             fp_valid,
  input  logic [WIDTH-1:0] fp_result,
  output logic             stall_ex,
  output logic             out_valid,
  output logic             out_we,
  output logic [RD_W-1:0]  out_rd,
  output logic [WIDTH-1:0] out_result,
  output logic             fp_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  exState_t state, stateNext;

  logic [RD_W-1:0]  rdLatch;
  logic [1:0]       opLatch;
  logic [WIDTH-1:0] aLatch, bLatch;

  logic [RD_W-1:0]  outRdQ;
  logic [WIDTH-1:0] outResultQ;
  logic             outValidQ;
  logic             fpTimeoutQ;

  logic stallRaw, startRaw, killRaw;
  logic acceptInt, acceptFp, finishFp, timeoutHit;
  logic cntClear, cntEn, cntTerm;

  ex_lat_counter #(
    .MAX_LAT(MAX_LAT)
  ) uLatCnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (cntClear),
    .en      (cntEn),
    .terminal(cntTerm)
  );

  // Next state and per-cycle decisions. Priority in BUSY: flush, then
  // fp_valid, then timeout, so a result landing on the final cycle is kept.
  always_comb begin
    stateNext  = state;
    stallRaw   = 1'b0;
    startRaw   = 1'b0;
    killRaw    = 1'b0;
    cntClear   = 1'b0;
    cntEn      = 1'b0;
    acceptInt  = 1'b0;
    acceptFp   = 1'b0;
    finishFp   = 1'b0;
    timeoutHit = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && !flush_e) begin
          if (in_is_fp) begin
            acceptFp  = 1'b1;
            stallRaw  = 1'b1;
            stateNext = ISSUE;
          end else begin
            acceptInt = 1'b1;
          end
        end
      end
      ISSUE: begin
        stallRaw = 1'b1;
        cntClear = 1'b1;
        if (flush_e) begin
          killRaw   = 1'b1;
          stateNext = IDLE;
        end else begin
          startRaw  = 1'b1;
          stateNext = BUSY;
        end
      end
      BUSY: begin
        stallRaw = !fp_valid;
        cntEn    = 1'b1;
        if (flush_e) begin
          killRaw   = 1'b1;
          stateNext = IDLE;
        end else if (fp_valid) begin
          finishFp  = 1'b1;
          stateNext = IDLE;
        end else if (cntTerm) begin
          timeoutHit = 1'b1;
          killRaw    = 1'b1;
          stateNext  = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Combinational outputs are masked during reset so a reset landing in
  // BUSY aborts silently (no kill pulse) and all outputs read zero.
  assign stall_ex = stallRaw & !reset;
  assign fp_start = startRaw & !reset;
  assign fp_kill  = killRaw & !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rdLatch    <= '0;
      opLatch    <= '0;
      aLatch     <= '0;
      bLatch     <= '0;
      outValidQ  <= 1'b0;
      outRdQ     <= '0;
      outResultQ <= '0;
      fpTimeoutQ <= 1'b0;
    end else begin
      state <= stateNext;
      if (acceptFp) begin
        rdLatch <= in_rd;
        opLatch <= in_fp_op;
        aLatch  <= in_fp_a;
        bLatch  <= in_fp_b;
      end
      outValidQ <= acceptInt | finishFp | timeoutHit;
      if (acceptInt) begin
        outRdQ     <= in_rd;
        outResultQ <= in_int_result;
      end else if (finishFp) begin
        outRdQ     <= rdLatch;
        outResultQ <= fp_result;
      end else if (timeoutHit) begin
        outRdQ     <= rdLatch;
        outResultQ <= '0;
      end
      if (timeoutHit) begin
        fpTimeoutQ <= 1'b1;
      end
    end
  end

  assign fp_op      = opLatch;
  assign fp_a       = aLatch;
  assign fp_b       = bLatch;
  assign out_valid  = outValidQ;
  assign out_rd     = outRdQ;
  assign out_result = outResultQ;
  assign out_we     = outValidQ & (outRdQ != '0);
  assign fp_timeout = fpTimeoutQ;

`ifdef EX_STALL_CNT_EN
  logic [CNT_W-1:0] stallCnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      stallCnt <= '0;
    end else if (stall_ex && (stallCnt != {CNT_W{1'b1}})) begin
      stallCnt <= stallCnt + 1'b1;
    end
  end

  assign stall_cycles = stallCnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fp_ex_seq.sv
// Purpose: scoreboard bench for fp_ex_seq; directed cases then randomized instruction stream.
// Latency: expectations carry the exact cycle each EX/MEM result must appear.
// Backpressure: the driver holds each FP instruction in EX for the cycles the model predicts.
module tb_fp_ex_seq;
  import ex_pkg::*;

  localparam int WIDTH   = 32;
  localparam int RD_W    = 5;
  localparam int MAX_LAT = 8;
  localparam int CNT_W   = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b1;
  logic             in_valid = 1'b0, in_is_fp = 1'b0, flush_e = 1'b0, fp_valid = 1'b0;
  logic [1:0]       in_fp_op = '0;
  logic [RD_W-1:0]  in_rd = '0;
  logic [WIDTH-1:0] in_int_result = '0, in_fp_a = '0, in_fp_b = '0, fp_result = '0;
  logic             fp_start, fp_kill, stall_ex, out_valid, out_we, fp_timeout;
  logic [1:0]       fp_op;
  logic [WIDTH-1:0] fp_a, fp_b, out_result;
  logic [RD_W-1:0]  out_rd;
  logic [CNT_W-1:0] stall_cycles;

  fp_ex_seq #(.WIDTH(WIDTH), .RD_W(RD_W), .MAX_LAT(MAX_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_is_fp(in_is_fp), .in_fp_op(in_fp_op),
    .in_rd(in_rd), .in_int_result(in_int_result), .in_fp_a(in_fp_a), .in_fp_b(in_fp_b),
    .flush_e(flush_e), .fp_start(fp_start), .fp_op(fp_op), .fp_a(fp_a), .fp_b(fp_b),
    .fp_kill(fp_kill), .fp_valid(fp_valid), .fp_result(fp_result), .stall_ex(stall_ex),
    .out_valid(out_valid), .out_we(out_we), .out_rd(out_rd), .out_result(out_result),
    .fp_timeout(fp_timeout), .stall_cycles(stall_cycles)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [RD_W-1:0] rd; logic [WIDTH-1:0] res; int due; logic to; } outExp_t;
  typedef struct { logic stall; logic start; logic kill; } ctl_t;
  typedef struct { logic [1:0] op; logic [WIDTH-1:0] a; logic [WIDTH-1:0] b; } iss_t;
  // lat: cycles from fp_start to fp_valid (0 = never answers); flushAt/spurAt: cycle offset
  // from accept (-1 = none); gap: idle cycles afterwards, first one optionally with fp_valid.
  typedef struct {
    bit isFp; logic [RD_W-1:0] rd; logic [WIDTH-1:0] val; logic [1:0] op;
    logic [WIDTH-1:0] a; logic [WIDTH-1:0] b;
    int lat; int flushAt; int spurAt; int gap; bit gapSpur;
  } op_t;

  outExp_t outQ[$];
  ctl_t    ctlQ[$];
  iss_t    issQ[$];

  logic    stickyTo = 1'b0;
  longint  stallSum = 0;
  int      killExp = 0, killSeen = 0;
  bit      monOn = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares per-cycle control expectations and pops EX/MEM results.
  always @(negedge clk) begin
    if (monOn) begin
      if (ctlQ.size() != 0) begin
        ctl_t c;
        c = ctlQ.pop_front();
        check("stall_ex", 64'(stall_ex), 64'(c.stall));
        check("fp_start", 64'(fp_start), 64'(c.start));
        check("fp_kill", 64'(fp_kill), 64'(c.kill));
      end
      if (fp_start && issQ.size() != 0) begin
        iss_t s;
        s = issQ.pop_front();
        check("fp_op", 64'(fp_op), 64'(s.op));
        check("fp_a", 64'(fp_a), 64'(s.a));
        check("fp_b", 64'(fp_b), 64'(s.b));
      end
      if (fp_kill) killSeen++;
      if (out_valid) begin
        if (outQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_valid_unexpected: got rd=%0d result=%0h expected no result (cycle %0d)",
                   out_rd, out_result, cyc);
        end else begin
          outExp_t e;
          e = outQ.pop_front();
          check("out_rd", 64'(out_rd), 64'(e.rd));
          check("out_result", 64'(out_result), 64'(e.res));
          check("out_we", 64'(out_we), 64'(e.rd != 0));
          check("out_cycle", 64'(cyc), 64'(e.due));
          check("fp_timeout", 64'(fp_timeout), 64'(e.to));
        end
      end
    end
  end

  task automatic tick(input logic stall, input logic start, input logic kill);
    ctl_t c;
    c.stall = stall; c.start = start; c.kill = kill;
    ctlQ.push_back(c);
    @(posedge clk);
    #1;
    stallSum += longint'(stall);
  endtask

  function automatic op_t mkOp(bit isFp, int rd, logic [WIDTH-1:0] val, int lat,
                               int flushAt, int spurAt, int gap, bit gapSpur);
    op_t o;
    o.isFp = isFp; o.rd = RD_W'(rd); o.val = val; o.op = 2'($urandom_range(0, 3));
    o.a = $urandom; o.b = $urandom; o.lat = lat; o.flushAt = flushAt;
    o.spurAt = spurAt; o.gap = gap; o.gapSpur = gapSpur;
    return o;
  endfunction

  // Drives one instruction and predicts its outcome from the instruction-level rules.
  task automatic runOp(input op_t o);
    int acc, doneK, endK;
    bit aborted, timedOut, answered;
    outExp_t e;
    iss_t s;
    acc = cyc;
    in_valid = 1'b1; in_is_fp = o.isFp; in_fp_op = o.op; in_rd = o.rd;
    in_int_result = o.isFp ? WIDTH'($urandom) : o.val; in_fp_a = o.a; in_fp_b = o.b;
    if (!o.isFp) begin
      flush_e = (o.flushAt == 0); fp_valid = (o.spurAt == 0); fp_result = $urandom;
      if (o.flushAt != 0) begin
        e.rd = o.rd; e.res = o.val; e.due = acc + 1; e.to = stickyTo;
        outQ.push_back(e);
      end
      tick(1'b0, 1'b0, 1'b0);
    end else if (o.flushAt == 0) begin
      flush_e = 1'b1; fp_valid = 1'b0;
      tick(1'b0, 1'b0, 1'b0);
    end else begin
      answered = (o.lat != 0) && (o.lat <= MAX_LAT);
      doneK    = answered ? 1 + o.lat : 1 + MAX_LAT;
      aborted  = (o.flushAt >= 1) && (o.flushAt <= doneK);
      endK     = aborted ? o.flushAt : doneK;
      timedOut = !aborted && !answered;
      if (o.flushAt != 1) begin
        s.op = o.op; s.a = o.a; s.b = o.b;
        issQ.push_back(s);
      end
      for (int k = 0; k <= endK; k++) begin
        logic v;
        v = ((o.lat != 0) && (k == 1 + o.lat)) || (k == o.spurAt);
        flush_e = (k == o.flushAt); fp_valid = v; fp_result = v ? o.val : WIDTH'($urandom);
        tick((k <= 1) ? 1'b1 : !v, (k == 1) && (o.flushAt != 1),
             (k == endK) && (aborted || timedOut));
      end
      if (aborted || timedOut) killExp++;
      if (timedOut) stickyTo = 1'b1;
      if (!aborted) begin
        e.rd = o.rd; e.res = timedOut ? '0 : o.val; e.due = acc + endK + 1; e.to = stickyTo;
        outQ.push_back(e);
      end
    end
    in_valid = 1'b0; flush_e = 1'b0; fp_valid = 1'b0;
    for (int g = 0; g < o.gap; g++) begin
      fp_valid = o.gapSpur && (g == 0);
      fp_result = $urandom;
      tick(1'b0, 1'b0, 1'b0);
    end
    fp_valid = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_we"}, 64'(out_we), 64'd0);
    check({tag, "_out_rd"}, 64'(out_rd), 64'd0);
    check({tag, "_out_result"}, 64'(out_result), 64'd0);
    check({tag, "_fp_timeout"}, 64'(fp_timeout), 64'd0);
    check({tag, "_stall_cycles"}, 64'(stall_cycles), 64'd0);
    check({tag, "_stall_ex"}, 64'(stall_ex), 64'd0);
    check({tag, "_fp_start"}, 64'(fp_start), 64'd0);
    check({tag, "_fp_kill"}, 64'(fp_kill), 64'd0);
    check({tag, "_fp_op"}, 64'(fp_op), 64'd0);
    check({tag, "_fp_a"}, 64'(fp_a), 64'd0);
    check({tag, "_fp_b"}, 64'(fp_b), 64'd0);
  endtask

  function automatic longint expStallCnt();
`ifdef EX_STALL_CNT_EN
    return stallSum;
`else
    return 0;
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    op_t dir[$];
    op_t o;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    reset = 1'b0;
    monOn = 1'b1;

    dir.push_back(mkOp(0, 5, 32'h0000_00AB, 0, -1, -1, 0, 0));
    dir.push_back(mkOp(1, 7, 32'h4040_0000, 3, -1, -1, 0, 0));
    dir.push_back(mkOp(1, 9, 32'h1111_2222, 0, -1, -1, 1, 0));        // timeout
    dir.push_back(mkOp(0, 6, 32'h0000_1234, 0, -1, -1, 0, 0));
    dir.push_back(mkOp(1, 3, 32'hDEAD_BEEF, 0, 3, -1, 1, 1));         // flush in BUSY 2, spurious valid
    dir.push_back(mkOp(0, 4, 32'h0000_0042, 0, -1, -1, 0, 0));
    dir.push_back(mkOp(1, 0, 32'h3F80_0000, 2, -1, -1, 0, 0));        // rd=0
    dir.push_back(mkOp(1, 11, 32'hAAAA_0001, 1, -1, -1, 0, 0));       // back-to-back minimum
    dir.push_back(mkOp(1, 12, 32'hAAAA_0002, 1, -1, -1, 0, 0));
    dir.push_back(mkOp(1, 13, 32'hBBBB_0001, MAX_LAT, -1, -1, 0, 0)); // valid on timeout cycle
    dir.push_back(mkOp(1, 14, 32'hBBBB_0002, MAX_LAT + 1, -1, -1, 0, 0));
    dir.push_back(mkOp(1, 15, 32'hCCCC_0001, 2, 1, -1, 0, 0));        // flush in ISSUE
    dir.push_back(mkOp(1, 16, 32'hCCCC_0002, 2, 0, -1, 0, 0));        // flush at accept
    dir.push_back(mkOp(1, 17, 32'hCCCC_0003, 2, 3, -1, 0, 0));        // flush with fp_valid
    dir.push_back(mkOp(1, 18, 32'hCCCC_0004, 2, -1, 1, 0, 0));        // valid during ISSUE
    foreach (dir[i]) runOp(dir[i]);

    for (int n = 0; n < 200; n++) begin
      o = mkOp($urandom_range(0, 1) == 1, ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 31),
               $urandom, ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, MAX_LAT + 2),
               ($urandom_range(0, 4) == 0) ? $urandom_range(0, MAX_LAT + 2) : -1,
               ($urandom_range(0, 5) == 0) ? $urandom_range(0, 1) : -1,
               $urandom_range(0, 2), $urandom_range(0, 1) == 1);
      runOp(o);
    end

    // Guarantee a set flag, then an FP op of latency 4, then reset mid-BUSY of the next.
    runOp(mkOp(1, 20, 32'h5555_0000, 0, -1, -1, 0, 0));
    runOp(mkOp(1, 21, 32'h4080_0000, 4, -1, -1, 0, 0));
    check("stall_cycles_pre", 64'(stall_cycles), 64'(expStallCnt()));
    check("fp_timeout_pre", 64'(fp_timeout), 64'(stickyTo));
    o = mkOp(1, 22, 32'h0, 0, -1, -1, 0, 0);
    begin
      iss_t s;
      s.op = o.op; s.a = o.a; s.b = o.b;
      issQ.push_back(s);
    end
    in_valid = 1'b1; in_is_fp = 1'b1; in_fp_op = o.op; in_rd = o.rd; in_fp_a = o.a; in_fp_b = o.b;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    check("stall_cycles_busy", 64'(stall_cycles), 64'(expStallCnt()));
    in_valid = 1'b0;
    reset = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    stickyTo = 1'b0;
    stallSum = 0;
    checkAllZero("midreset");

    runOp(mkOp(0, 8, 32'h0000_0777, 0, -1, -1, 0, 0));
    runOp(mkOp(1, 9, 32'h4000_0000, 2, -1, -1, 2, 0));
    check("stall_cycles_end", 64'(stall_cycles), 64'(expStallCnt()));

    check("out_queue_drained", 64'(outQ.size()), 64'd0);
    check("issue_queue_drained", 64'(issQ.size()), 64'd0);
    check("ctl_queue_drained", 64'(ctlQ.size()), 64'd0);
    check("kill_count", 64'(killSeen), 64'(killExp));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
